pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central stall/flush controller for the 5-stage scalar/vector pipeline. It sits directly downstream of the forwarding/hazard logic and consumes its load-use stall request, the E-stage branch redirect, the E-stage multi-cycle-op request (div/fdiv/fsqrt) and the M-stage memory-busy signal. From these it produces per-stage stall and flush enables for the F/D, D/E, E/M and M/W pipeline registers. It also keeps stall/flush performance counters.

Parameters:
LAT_W, 5, width of multi-cycle latency field (max op latency 2^LAT_W-1)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
lwstall  in  1  load-use / vector-dependency stall request for the instruction in D
branch_takenE  in  1  redirect from the instruction in E
mc_startE  in  1  instruction in E is multi-cycle; held high while it remains in E
mc_latE  in  LAT_W  total E-residency of that op in cycles
mem_busyM  in  1  M stage cannot complete this cycle (cache miss/UART wait)
stallF  out  1  hold PC
stallD  out  1  hold F/D register
stallE  out  1  hold D/E register
stallM  out  1  hold E/M register
flushD  out  1  clear F/D register to bubble
flushE  out  1  clear D/E register to bubble
flushM  out  1  clear E/M register to bubble
mc_busy  out  1  FSM in MC_WAIT
stall_cycles  out  CNT_W  cycles with stallF=1
flush_count  out  CNT_W  cycles with branch-induced flushD=1

Behaviour:
- Reset (rstn=0, async): state=RUN, cnt=0, stall_cycles=0, flush_count=0. While rstn=0: all stalls=0; flushD=flushE=flushM=1 (pipeline cleared); mc_busy=0.
- Outputs are combinational from state, cnt and inputs. Counters and state update on posedge clk.
- Priority, highest first: mem_busyM > MC_WAIT > branch_takenE > multi-cycle start > lwstall.
- mem_busyM=1 (any state): stallF=stallD=stallE=stallM=1, all flushes 0. FSM and cnt frozen. A pending branch or multi-cycle start is not acted on; the instruction stays in E and is re-evaluated once mem_busyM=0.
- State RUN, mem_busyM=0:
  - branch_takenE=1: flushD=flushE=1, stalls 0. lwstall is ignored, since the D instruction is killed.
  - else mc_startE=1 and mc_latE>=2: stallF=stallD=stallE=1, flushM=1 (bubble into M). Next state MC_WAIT with cnt=mc_latE-2.
  - else mc_startE=1 and mc_latE<=1: treated as a single-cycle op; no action.
  - else lwstall=1: stallF=stallD=1, flushE=1.
  - else: all outputs 0.
- State MC_WAIT, mem_busyM=0:
  - If cnt!=0: stallF=stallD=stallE=1, flushM=1, cnt decrements.
  - If cnt==0: all stalls 0, flushM=0; the op leaves E at this edge and the next state is RUN.
  - mc_startE, branch_takenE and lwstall are ignored in MC_WAIT.
  - Total E residency is exactly mc_latE cycles when mem_busyM stays low.
- lwstall arriving in the MC_WAIT exit cycle: acted on next cycle in RUN. Hazard logic re-evaluates it against the new E contents.
- stall_cycles increments each cycle stallF=1 (rstn=1). flush_count increments each cycle branch_takenE causes flushD. Both wrap modulo 2^CNT_W.
- Reset asserted mid-MC_WAIT: immediate return to RUN; the in-flight op is discarded by the flushes.

Decomposition:
- Package pipeline_pkg:
  - typedef enum logic [0:0] {RUN, MC_WAIT} pctrl_state_t
  - localparams LAT_W_DEF=5, CNT_W_DEF=32
  - struct pipe_ctrl_t {stall, flush} per stage, for reuse by the pipeline registers
- Sub-module perf_counter (CNT_W, inc input, async active-low reset), instantiated twice.

Test Plan:
- Reset: rstn=0 -> flushD=flushE=flushM=1, stalls=0, counters=0. Release -> all outputs 0 when inputs idle.
- lwstall=1 for 1 cycle in RUN -> stallF=stallD=flushE=1 for that cycle only; stall_cycles=1.
- mc_startE=1, mc_latE=4 -> stallF/D/E=1 and flushM=1 for 3 cycles, 0 on the 4th cycle; mc_busy high cycles 2-4; state back to RUN; stall_cycles=3. With mc_latE=1 -> no stall.
- branch_takenE=1 with lwstall=1 simultaneously -> flushD=flushE=1, stallF=stallD=0; flush_count=1.
- mc_latE=3 with mem_busyM=1 asserted in cycle 2 for 2 cycles -> all four stalls=1 and flushes 0 during busy; cnt frozen; multi-cycle stalls resume afterwards; E residency = 3 + 2 cycles.
- Reset pulse while in MC_WAIT with cnt=5 -> state RUN, mc_busy=0 immediately (asynchronous), flushes asserted during reset.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
package pipeline_pkg;

  localparam int unsigned LAT_W_DEF = 5;
  localparam int unsigned CNT_W_DEF = 32;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } pctrl_state_t;

  // Hold/clear controls for one pipeline register.
  typedef struct packed {
    logic stall;
    logic flush;
  } pipe_ctrl_t;

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter; wraps modulo 2^CNT_W.
module perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count one per cycle while inc is high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Arbitrates memory busy, multi-cycle E ops, branch redirects and load-use
// stalls into per-register stall/flush enables, plus perf counters.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned LAT_W = LAT_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             lwstall,
  input  logic             branch_takenE,
  input  logic             mc_startE,
  input  logic [LAT_W-1:0] mc_latE,
  input  logic             mem_busyM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  pctrl_state_t     state, state_nxt;
  logic [LAT_W-1:0] cnt, cnt_nxt;

  logic       stall_f;
  pipe_ctrl_t ctrl_d;
  pipe_ctrl_t ctrl_e;
  pipe_ctrl_t ctrl_m;
  logic       branch_flush;

  // Prioritised control decode: reset, mem busy, MC_WAIT, branch, mc start, load-use.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    stall_f      = 1'b0;
    ctrl_d       = '0;
    ctrl_e       = '0;
    ctrl_m       = '0;
    branch_flush = 1'b0;

    if (!rstn) begin
      ctrl_d.flush = 1'b1;
      ctrl_e.flush = 1'b1;
      ctrl_m.flush = 1'b1;
    end else if (mem_busyM) begin
      stall_f      = 1'b1;
      ctrl_d.stall = 1'b1;
      ctrl_e.stall = 1'b1;
      ctrl_m.stall = 1'b1;
    end else if (state == MC_WAIT) begin
      if (cnt != '0) begin
        stall_f      = 1'b1;
        ctrl_d.stall = 1'b1;
        ctrl_e.stall = 1'b1;
        ctrl_m.flush = 1'b1;
        cnt_nxt      = cnt - LAT_W'(1);
      end else begin
        state_nxt = RUN;
      end
    end else if (branch_takenE) begin
      ctrl_d.flush = 1'b1;
      ctrl_e.flush = 1'b1;
      branch_flush = 1'b1;
    end else if (mc_startE && (mc_latE >= LAT_W'(2))) begin
      stall_f      = 1'b1;
      ctrl_d.stall = 1'b1;
      ctrl_e.stall = 1'b1;
      ctrl_m.flush = 1'b1;
      state_nxt    = MC_WAIT;
      cnt_nxt      = mc_latE - LAT_W'(2);
    end else if (!mc_startE && lwstall) begin
      // A short multi-cycle op (latency <= 1) outranks lwstall and does nothing.
      stall_f      = 1'b1;
      ctrl_d.stall = 1'b1;
      ctrl_e.flush = 1'b1;
    end
  end

  // State and residency counter; frozen by mem busy through the decode above.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign stallF  = stall_f;
  assign stallD  = ctrl_d.stall;
  assign flushD  = ctrl_d.flush;
  assign stallE  = ctrl_e.stall;
  assign flushE  = ctrl_e.flush;
  assign stallM  = ctrl_m.stall;
  assign flushM  = ctrl_m.flush;
  assign mc_busy = (state == MC_WAIT);

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (stall_f),
    .count (stall_cycles)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (branch_flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus random traffic against
// a residency-based reference model.
module tb_pipeline_ctrl;

  localparam int unsigned LAT_W = 5;
  localparam int unsigned CNT_W = 32;

  logic             clk;
  logic             rstn;
  logic             lwstall;
  logic             branch_takenE;
  logic             mc_startE;
  logic [LAT_W-1:0] mc_latE;
  logic             mem_busyM;
  logic             stallF, stallD, stallE, stallM;
  logic             flushD, flushE, flushM;
  logic             mc_busy;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  int checks;
  int failures;

  // Reference model: an accepted multi-cycle op occupies E for m_lat
  // non-busy cycles; m_p counts the ones already completed.
  bit          m_active;
  int unsigned m_lat;
  int unsigned m_p;
  int unsigned m_stall_cnt;
  int unsigned m_flush_cnt;
  logic [7:0]  exp_vec;
  bit          exp_bf;

  pipeline_ctrl #(.LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .lwstall       (lwstall),
    .branch_takenE (branch_takenE),
    .mc_startE     (mc_startE),
    .mc_latE       (mc_latE),
    .mem_busyM     (mem_busyM),
    .stallF        (stallF),
    .stallD        (stallD),
    .stallE        (stallE),
    .stallM        (stallM),
    .flushD        (flushD),
    .flushE        (flushE),
    .flushM        (flushM),
    .mc_busy       (mc_busy),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Order: stallF stallD stallE stallM flushD flushE flushM mc_busy
  function automatic logic [7:0] obs_vec();
    return {stallF, stallD, stallE, stallM, flushD, flushE, flushM, mc_busy};
  endfunction

  // Drive one cycle's inputs at negedge and compute the expected controls.
  task automatic apply(input logic r, input logic lw, input logic br,
                       input logic mc, input logic [LAT_W-1:0] lat, input logic mem);
    bit sf, sd, se, sm, fd, fe, fm;
    @(negedge clk);
    rstn = r; lwstall = lw; branch_takenE = br;
    mc_startE = mc; mc_latE = lat; mem_busyM = mem;
    if (!r) begin
      m_active = 0; m_lat = 0; m_p = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    end
    sf = 0; sd = 0; se = 0; sm = 0; fd = 0; fe = 0; fm = 0; exp_bf = 0;
    if (!r) begin
      fd = 1; fe = 1; fm = 1;
    end else if (mem) begin
      sf = 1; sd = 1; se = 1; sm = 1;
    end else if (m_active) begin
      if (m_p + 1 < m_lat) begin sf = 1; sd = 1; se = 1; fm = 1; end
    end else if (br) begin
      fd = 1; fe = 1; exp_bf = 1;
    end else if (mc) begin
      if (lat >= 5'd2) begin sf = 1; sd = 1; se = 1; fm = 1; end
    end else if (lw) begin
      sf = 1; sd = 1; fe = 1;
    end
    exp_vec = {sf, sd, se, sm, fd, fe, fm, m_active};
    #1;
  endtask

  // Clock edge: advance the model with the inputs held over the edge.
  task automatic advance();
    @(posedge clk);
    if (rstn) begin
      m_stall_cnt += 32'(exp_vec[7]);
      m_flush_cnt += 32'(exp_bf);
      if (!mem_busyM) begin
        if (m_active) begin
          m_p++;
          if (m_p >= m_lat) m_active = 0;
        end else if (!branch_takenE && mc_startE && mc_latE >= 5'd2) begin
          m_active = 1; m_lat = 32'(mc_latE); m_p = 1;
        end
      end
    end
  endtask

  task automatic test_reset();
    apply(0, 0, 0, 0, 5'd0, 0);
    checks++;
    if (obs_vec() !== 8'b0000_1110) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=%b", obs_vec(), 8'b0000_1110);
    end
    checks++;
    if (stall_cycles !== 0 || flush_count !== 0) begin
      failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cycles, flush_count);
    end
    advance();
    apply(1, 0, 0, 0, 5'd0, 0);
    checks++;
    if (obs_vec() !== 8'b0) begin
      failures++; $display("FAIL reset_idle got=%b exp=%b", obs_vec(), 8'b0);
    end
    advance();
  endtask

  task automatic test_lwstall();
    apply(1, 1, 0, 0, 5'd0, 0);
    checks++;
    if (obs_vec() !== 8'b1100_0100) begin
      failures++; $display("FAIL lw_ctrl got=%b exp=%b", obs_vec(), 8'b1100_0100);
    end
    advance();
    apply(1, 0, 0, 0, 5'd0, 0);
    checks++;
    if (obs_vec() !== 8'b0) begin
      failures++; $display("FAIL lw_release got=%b exp=%b", obs_vec(), 8'b0);
    end
    checks++;
    if (stall_cycles !== 32'd1) begin
      failures++; $display("FAIL lw_stall_cycles got=%0d exp=1", stall_cycles);
    end
    advance();
  endtask

  task automatic test_multicycle();
    int unsigned base;
    base = m_stall_cnt;
    for (int i = 0; i < 4; i++) begin
      apply(1, 0, 0, 1, 5'd4, 0);
      checks++;
      if (obs_vec() !== exp_vec || stallF !== (i < 3) || mc_busy !== (i > 0)) begin
        failures++; $display("FAIL mc4_cyc%0d got=%b exp=%b", i, obs_vec(), exp_vec);
      end
      advance();
    end
    apply(1, 0, 0, 0, 5'd0, 0);
    checks++;
    if (obs_vec() !== 8'b0 || stall_cycles !== 32'(base + 3)) begin
      failures++; $display("FAIL mc4_done got=%b cnt=%0d exp=0 cnt=%0d", obs_vec(), stall_cycles, base + 3);
    end
    advance();
    apply(1, 0, 0, 1, 5'd1, 0);
    checks++;
    if (obs_vec() !== 8'b0) begin
      failures++; $display("FAIL mc1_nostall got=%b exp=%b", obs_vec(), 8'b0);
    end
    advance();
    apply(1, 0, 0, 0, 5'd0, 0);
    checks++;
    if (stall_cycles !== 32'(base + 3)) begin
      failures++; $display("FAIL mc1_cnt got=%0d exp=%0d", stall_cycles, base + 3);
    end
    advance();
  endtask

  task automatic test_branch_lw();
    int unsigned base;
    base = m_flush_cnt;
    apply(1, 1, 1, 0, 5'd0, 0);
    checks++;
    if (obs_vec() !== 8'b0000_1100) begin
      failures++; $display("FAIL br_lw_ctrl got=%b exp=%b", obs_vec(), 8'b0000_1100);
    end
    advance();
    apply(1, 0, 0, 0, 5'd0, 0);
    checks++;
    if (flush_count !== 32'(base + 1)) begin
      failures++; $display("FAIL br_flush_count got=%0d exp=%0d", flush_count, base + 1);
    end
    advance();
  endtask

  task automatic test_mem_busy_mc();
    logic mem_seq [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      apply(1, 0, 0, 1, 5'd3, mem_seq[i]);
      checks++;
      if (obs_vec() !== exp_vec || (mem_seq[i] && obs_vec() !== 8'b1111_0001)) begin
        failures++; $display("FAIL membusy_cyc%0d got=%b exp=%b", i, obs_vec(), exp_vec);
      end
      advance();
    end
    apply(1, 0, 0, 0, 5'd0, 0);
    checks++;
    if (mc_busy !== 1'b0 || obs_vec() !== 8'b0) begin
      failures++; $display("FAIL membusy_exit got=%b exp=%b", obs_vec(), 8'b0);
    end
    advance();
  endtask

  task automatic test_reset_mid_mc();
    for (int i = 0; i < 2; i++) begin
      apply(1, 0, 0, 1, 5'd8, 0);
      checks++;
      if (obs_vec() !== exp_vec) begin
        failures++; $display("FAIL rstmc_cyc%0d got=%b exp=%b", i, obs_vec(), exp_vec);
      end
      advance();
    end
    apply(0, 0, 0, 1, 5'd8, 0);
    checks++;
    if (obs_vec() !== 8'b0000_1110 || stall_cycles !== 0 || flush_count !== 0) begin
      failures++; $display("FAIL rstmc_async got=%b cnt=%0d exp=%b cnt=0", obs_vec(), stall_cycles, 8'b0000_1110);
    end
    advance();
    apply(1, 0, 0, 0, 5'd0, 0);
    checks++;
    if (obs_vec() !== 8'b0) begin
      failures++; $display("FAIL rstmc_idle got=%b exp=%b", obs_vec(), 8'b0);
    end
    advance();
  endtask

  task automatic test_random();
    logic             r, lw, br, mc, mem;
    logic [LAT_W-1:0] lat;
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 99) != 0);
      lw  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 5) == 0);
      mem = ($urandom_range(0, 4) == 0);
      if (m_active) begin
        mc  = 1'b1;
        lat = 5'(m_lat);
      end else begin
        mc  = ($urandom_range(0, 4) == 0);
        lat = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      end
      apply(r, lw, br, mc, lat, mem);
      checks++;
      if (obs_vec() !== exp_vec) begin
        failures++; $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec);
      end
      checks++;
      if (stall_cycles !== 32'(m_stall_cnt) || flush_count !== 32'(m_flush_cnt)) begin
        failures++;
        $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", i,
                 stall_cycles, flush_count, m_stall_cnt, m_flush_cnt);
      end
      advance();
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    m_active = 0; m_lat = 0; m_p = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    exp_vec = '0; exp_bf = 0;
    rstn = 1'b0; lwstall = 1'b0; branch_takenE = 1'b0;
    mc_startE = 1'b0; mc_latE = '0; mem_busyM = 1'b0;
    test_reset();
    test_lwstall();
    test_multicycle();
    test_branch_lw();
    test_mem_busy_mc();
    test_reset_mid_mc();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
